onchip_ram_dp_avmm: RTL and testbench

- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 and s2.
- Adds pipelined reads with readdatavalid, a selectable read latency, a hardware clear engine (after reset and on request), a clock-enable stall and write-collision detection.
- Sits on the Nios II data/instruction interconnect as the successor to the single-port 32-bit on-chip memory.

---
 rtl/onchip_ram_pkg.sv | 9 +
 rtl/onchip_ram_dp_core.sv | 50 +++++
 rtl/onchip_ram_dp_avmm.sv | 145 ++++++++++++++
 tb/tb_onchip_ram_dp_avmm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// onchip_ram_pkg: shared FSM state, byte-lane width helper and read latency bounds
package onchip_ram_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/onchip_ram_dp_core.sv
// onchip_ram_dp_core: byte-enabled true-dual-port array with registered reads; port a wins on overlap
module onchip_ram_dp_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 23719,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BE_W-1:0]   a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BE_W-1:0]   b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic a_ok, b_ok;
  logic [IW-1:0] a_idx, b_idx;
  assign a_ok  = {1'b0, a_addr} < LIM;
  assign b_ok  = {1'b0, b_addr} < LIM;
  assign a_idx = a_addr[IW-1:0];
  assign b_idx = b_addr[IW-1:0];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_we && b_ok && b_be[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_we && a_ok && a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (en) begin
      if (a_re) a_rdata <= a_ok ? mem[a_idx] : '0;
      if (b_re) b_rdata <= b_ok ? mem[b_idx] : '0;
    end
  end
endmodule

// File: rtl/onchip_ram_dp_avmm.sv
// onchip_ram_dp_avmm: dual Avalon-MM port RAM with clear engine, stall and collision flag
// ONCHIP_RAM_BYPASS_EN: forward same-cycle cross-port write data to a read of that address
module onchip_ram_dp_avmm
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int DEPTH          = 23719,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      collision,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [ADDR_W-1:0]         s1_address,
  input  logic [be_w(DATA_W)-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]         s1_writedata,
  output logic [DATA_W-1:0]         s1_readdata,
  output logic                      s1_readdatavalid,
  output logic                      s1_waitrequest,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [ADDR_W-1:0]         s2_address,
  input  logic [be_w(DATA_W)-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]         s2_writedata,
  output logic [DATA_W-1:0]         s2_readdata,
  output logic                      s2_readdatavalid,
  output logic                      s2_waitrequest
);
  localparam int BW = be_w(DATA_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_ptr;
  logic clr_done, stall, acc1, acc2, wr1, wr2, rd1, rd2, w2, coll_now;
  logic [1:0] v1;
  logic [DATA_W-1:0] q1, q2, r1, r2;
  assign clr_done = clr_ptr == LAST;
  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
    else if (clken) state <= state_n;
  end
  always_comb state_n = state == IDLE ? (clear_req ? CLEAR : IDLE) : (clr_done ? IDLE : CLEAR);
  always_comb clear_busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (reset) clr_ptr <= '0;
    else if (clken && clear_busy) clr_ptr <= clr_done ? '0 : clr_ptr + 1'b1;
  end
  assign stall          = clear_busy | ~clken;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;
  assign acc1     = s1_chipselect & (s1_read | s1_write) & ~stall;
  assign acc2     = s2_chipselect & (s2_read | s2_write) & ~stall;
  assign wr1      = acc1 & s1_write;
  assign wr2      = acc2 & s2_write;
  assign rd1      = acc1 & s1_read & ~s1_write;
  assign rd2      = acc2 & s2_read & ~s2_write;
  assign coll_now = wr1 & wr2 & (s1_address == s2_address);
  assign w2       = wr2 & ~coll_now;
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else if (coll_now) collision <= 1'b1;
  end
  // the sweep borrows port a, which is free because waitrequest blocks every command
  onchip_ram_dp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BE_W(BW)) u_core (
    .clk(clk), .rst(reset), .en(clken),
    .a_we(clear_busy | wr1), .a_re(rd1),
    .a_addr(clear_busy ? clr_ptr : s1_address),
    .a_be(clear_busy ? {BW{1'b1}} : s1_byteenable),
    .a_wdata(clear_busy ? '0 : s1_writedata), .a_rdata(q1),
    .b_we(w2), .b_re(rd2), .b_addr(s2_address), .b_be(s2_byteenable),
    .b_wdata(s2_writedata), .b_rdata(q2)
  );
  always_ff @(posedge clk) begin
    if (reset) v1 <= '0;
    else if (clken) v1 <= {rd2, rd1};
  end
`ifdef ONCHIP_RAM_BYPASS_EN
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] m1, m2, fm1, fd1, fm2, fd2;
  logic hit1, hit2;
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < BW; i++) begin
      m1[8*i +: 8] = {8{s1_byteenable[i]}};
      m2[8*i +: 8] = {8{s2_byteenable[i]}};
    end
  end
  assign hit1 = w2 & (s2_address == s1_address) & ({1'b0, s2_address} < LIM);
  assign hit2 = wr1 & (s1_address == s2_address) & ({1'b0, s1_address} < LIM);
  always_ff @(posedge clk) begin
    if (reset) begin
      fm1 <= '0;
      fd1 <= '0;
      fm2 <= '0;
      fd2 <= '0;
    end else if (clken) begin
      if (rd1) begin
        fm1 <= hit1 ? m2 : '0;
        fd1 <= s2_writedata;
      end
      if (rd2) begin
        fm2 <= hit2 ? m1 : '0;
        fd2 <= s1_writedata;
      end
    end
  end
  assign r1 = (q1 & ~fm1) | (fd1 & fm1);
  assign r2 = (q2 & ~fm2) | (fd2 & fm2);
`else
  assign r1 = q1;
  assign r2 = q2;
`endif
  if (RD_LATENCY == RD_LAT_MAX) begin : g_l2
    logic [DATA_W-1:0] o1, o2;
    logic [1:0] v2;
    always_ff @(posedge clk) begin
      if (reset) begin
        v2 <= '0;
        o1 <= '0;
        o2 <= '0;
      end else if (clken) begin
        v2 <= v1;
        if (v1[0]) o1 <= r1;
        if (v1[1]) o2 <= r2;
      end
    end
    assign s1_readdata      = o1;
    assign s2_readdata      = o2;
    assign s1_readdatavalid = v2[0];
    assign s2_readdatavalid = v2[1];
  end else begin : g_l1
    assign s1_readdata      = r1;
    assign s2_readdata      = r2;
    assign s1_readdatavalid = v1[0];
    assign s2_readdatavalid = v1[1];
  end
endmodule

// File: tb/tb_onchip_ram_dp_avmm.sv
// tb_onchip_ram_dp_avmm: scoreboard bench for the dual-port Avalon-MM RAM (DEPTH=16)
module tb_onchip_ram_dp_avmm;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int D  = 16;
  localparam int L  = 1;
`ifdef ONCHIP_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, clken, clear_req, clear_busy, collision;
  logic s1_chipselect, s1_read, s1_write, s1_readdatavalid, s1_waitrequest;
  logic s2_chipselect, s2_read, s2_write, s2_readdatavalid, s2_waitrequest;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t q1[$], q2[$];
  int n_cmp = 0, n_bad = 0, ecyc = 0;
  logic en_q = 1'b0;
  always #5 clk = ~clk;
  onchip_ram_dp_avmm #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RD_LATENCY(L), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .clken(clken), .clear_req(clear_req),
    .clear_busy(clear_busy), .collision(collision),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );
  always @(posedge clk) begin
    en_q <= clken;
    if (clken) ecyc <= ecyc + 1;
  end
  // only a fresh enabled edge can deliver a new beat; held outputs during a stall are not re-counted
  always @(negedge clk) begin
    exp_t e;
    if (en_q) begin
      if (s1_readdatavalid) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_bad++;
          $display("FAIL s1_spurious_valid: got data %h with nothing expected", s1_readdata);
        end else begin
          e = q1.pop_front();
          if (s1_readdata !== e.d || ecyc !== e.c) begin
            n_bad++;
            $display("FAIL s1_read: got %h at cycle %0d, want %h at cycle %0d", s1_readdata, ecyc, e.d, e.c);
          end
        end
      end else if (q1.size() != 0 && q1[0].c <= ecyc) begin
        n_cmp++;
        n_bad++;
        e = q1.pop_front();
        $display("FAIL s1_missing_valid: no beat at cycle %0d, want %h", ecyc, e.d);
      end
      if (s2_readdatavalid) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_bad++;
          $display("FAIL s2_spurious_valid: got data %h with nothing expected", s2_readdata);
        end else begin
          e = q2.pop_front();
          if (s2_readdata !== e.d || ecyc !== e.c) begin
            n_bad++;
            $display("FAIL s2_read: got %h at cycle %0d, want %h at cycle %0d", s2_readdata, ecyc, e.d, e.c);
          end
        end
      end else if (q2.size() != 0 && q2[0].c <= ecyc) begin
        n_cmp++;
        n_bad++;
        e = q2.pop_front();
        $display("FAIL s2_missing_valid: no beat at cycle %0d, want %h", ecyc, e.d);
      end
    end
  end
  task automatic idle_bus();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask
  task automatic issue(input logic r1, w1, input logic [AW-1:0] a1, input logic [31:0] d1,
                       input logic [3:0] b1, input logic [31:0] e1,
                       input logic r2, w2, input logic [AW-1:0] a2, input logic [31:0] d2,
                       input logic [3:0] b2, input logic [31:0] e2);
    s1_chipselect = r1 | w1; s1_read = r1; s1_write = w1; s1_address = a1; s1_byteenable = b1; s1_writedata = d1;
    s2_chipselect = r2 | w2; s2_read = r2; s2_write = w2; s2_address = a2; s2_byteenable = b2; s2_writedata = d2;
    if (r1 && !w1) q1.push_back('{d: e1, c: ecyc + L});
    if (r2 && !w2) q2.push_back('{d: e2, c: ecyc + L});
    @(negedge clk);
    idle_bus();
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: %0d/%0d reads outstanding, want 0", tag, q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask
  task automatic busy_count(input string tag);
    int cnt = 0;
    while (clear_busy && cnt < 100) begin
      n_cmp++;
      if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_wait_during_sweep: got %b%b, want 11", tag, s1_waitrequest, s2_waitrequest);
      end
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt !== D) begin
      n_bad++;
      $display("FAIL %s_sweep_len: got %0d cycles, want %0d", tag, cnt, D);
    end
    n_cmp++;
    if (s1_waitrequest !== 1'b0 || s2_waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_wait_after_sweep: got %b%b, want 00", tag, s1_waitrequest, s2_waitrequest);
    end
  endtask
  task automatic test_reset();
    reset = 1; clken = 1; clear_req = 0; idle_bus();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({clear_busy, s1_waitrequest, s2_waitrequest} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_busy_wait: got %b, want 111", {clear_busy, s1_waitrequest, s2_waitrequest});
    end
    n_cmp++;
    if ({collision, s1_readdatavalid, s2_readdatavalid} !== 3'b000 || s1_readdata !== 0 || s2_readdata !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got flags %b data %h %h, want 000 0 0",
               {collision, s1_readdatavalid, s2_readdatavalid}, s1_readdata, s2_readdata);
    end
    reset = 0;
    busy_count("reset");
    issue(1, 0, 5, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    drain("reset");
  endtask
  task automatic test_byteenable();
    issue(0, 1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 3, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 32'hDE22BE44);
    drain("byteenable");
  endtask
  task automatic test_collision();
    n_cmp++;
    if (collision !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_pre: got %b, want 0", collision);
    end
    issue(0, 1, 7, 32'hAAAAAAAA, 4'hF, 0, 0, 1, 7, 32'h55555555, 4'hF, 0);
    issue(1, 0, 7, 0, 0, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (collision !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_sticky: got %b, want 1", collision);
    end
    drain("collision");
  endtask
  task automatic test_read_during_write();
    issue(0, 1, 9, 32'h12345678, 4'hF, 0, 1, 0, 9, 0, 0, BYP ? 32'h12345678 : 32'h0);
    issue(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 32'h12345678);
    issue(1, 0, 10, 0, 0, BYP ? 32'h0000ABCD : 32'h0, 0, 1, 10, 32'h9999ABCD, 4'h3, 0);
    issue(1, 0, 10, 0, 0, 32'h0000ABCD, 0, 0, 0, 0, 0, 0);
    drain("rdw");
  endtask
  task automatic test_range_and_rw();
    issue(0, 1, 4, 32'h01020304, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 20, 0, 0, 32'h0, 1, 0, 4, 0, 0, 32'h01020304);
    issue(1, 1, 11, 32'h00000077, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 11, 0, 0, 32'h00000077, 0, 0, 0, 0, 0, 0);
    drain("range_rw");
  endtask
  task automatic test_back_to_back();
    logic held;
    for (int i = 0; i < 8; i++) issue(0, 0, 0, 0, 0, 0, 0, 1, AW'(i), 32'h100 + i, 4'hF, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        clken = 0;
        held = s1_readdatavalid;
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if (s1_readdatavalid !== held || s1_waitrequest !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold: got valid %b wait %b, want %b 1", s1_readdatavalid, s1_waitrequest, held);
          end
        end
        clken = 1;
      end
      issue(1, 0, AW'(i), 0, 0, 32'h100 + i, 0, 0, 0, 0, 0, 0);
    end
    drain("b2b");
  endtask
  task automatic test_clear();
    issue(0, 1, 2, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    clear_req = 1;
    issue(1, 0, 2, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
    clear_req = 0;
    s1_chipselect = 1; s1_write = 1; s1_address = 2; s1_byteenable = 4'hF; s1_writedata = 32'h00000BAD;
    busy_count("clear");
    idle_bus();
    issue(1, 0, 2, 0, 0, 32'h0, 1, 0, 7, 0, 0, 32'h0);
    drain("clear");
  endtask
  task automatic test_reset_midsweep();
    n_cmp++;
    if (collision !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_before_reset: got %b, want 1", collision);
    end
    s1_chipselect = 1; s1_read = 1; s1_address = 4; reset = 1;
    @(negedge clk);
    idle_bus(); reset = 0;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_cmp++;
    if (collision !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_after_reset: got %b, want 0", collision);
    end
    busy_count("midsweep");
    issue(1, 0, 4, 0, 0, 32'h0, 1, 0, 9, 0, 0, 32'h0);
    drain("midsweep");
  endtask
  initial begin
    test_reset();
    test_byteenable();
    test_collision();
    test_read_during_write();
    test_range_and_rw();
    test_back_to_back();
    test_clear();
    test_reset_midsweep();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
